// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the sequencer state encoding, the RUN-state action decode and the
// per-latch control bundle together with its fixed patterns.
package pipeline_stall_controller_pkg;

    // Default number of cycles HALT needs to walk through EX, MEM and WB.
    localparam int unsigned DefaultDrainCycles = 3;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDmemWait = 2'd1,
        StDrain    = 2'd2,
        StHalted   = 2'd3
    } ctrlState_e;

    // Action selected in RUN, already resolved by priority.
    typedef enum logic [2:0] {
        ActNone      = 3'd0,
        ActMemHold   = 3'd1,
        ActRedirect  = 3'd2,
        ActImemStall = 3'd3,
        ActLoadUse   = 3'd4,
        ActHalt      = 3'd5
    } runAction_e;

    // Latch enables and bubble-insert controls, PC first, WB last.
    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic idexEn;
        logic exmemEn;
        logic memwbEn;
        logic ifidFlush;
        logic idexFlush;
        logic exmemFlush;
        logic memwbFlush;
    } latchCtrl_t;

    // Builds a control bundle from {pc,ifid,idex,exmem,memwb} enables and
    // {ifid,idex,exmem,memwb} flushes.
    function automatic latchCtrl_t mkCtrl(input logic [4:0] en, input logic [3:0] flush);
        latchCtrl_t c;
        c = latchCtrl_t'({en, flush});
        return c;
    endfunction

    localparam latchCtrl_t CtrlReset    = mkCtrl(5'b00000, 4'b1111);
    localparam latchCtrl_t CtrlAllEn    = mkCtrl(5'b11111, 4'b0000);
    // Only MEM/WB moves, and it takes a bubble while the data access is pending.
    localparam latchCtrl_t CtrlMemHold  = mkCtrl(5'b00001, 4'b0001);
    // Wrong-path instructions in IF and ID are squashed.
    localparam latchCtrl_t CtrlRedirect = mkCtrl(5'b11111, 4'b1100);
    localparam latchCtrl_t CtrlImemWait = mkCtrl(5'b01111, 4'b1000);
    localparam latchCtrl_t CtrlLoadUse  = mkCtrl(5'b00111, 4'b0100);
    // HALT moves into EX while fetch and ID freeze behind it.
    localparam latchCtrl_t CtrlHaltIss  = mkCtrl(5'b00111, 4'b0000);
    localparam latchCtrl_t CtrlDrain    = mkCtrl(5'b00111, 4'b1000);
    localparam latchCtrl_t CtrlHalted   = mkCtrl(5'b00000, 4'b0000);

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Load-use hazard detector.
// Flags when the instruction in EX is a load whose destination is read by the
// instruction in ID. Rs and Rt are compared independently; register 0 is an
// ordinary register in this ISA, so it is not excluded.
module pipeline_stall_controller_load_use_detect #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_usesRs,
    input  logic                  IFID_usesRt,
    input  logic                  IDEX_MemToReg,
    input  logic                  IDEX_RegWrite,
    input  logic [REG_ADDR_W-1:0] IDEX_WriteReg,
    output logic                  hazard
);

    logic rsMatch;
    logic rtMatch;
    logic exIsLoad;

    assign exIsLoad = IDEX_MemToReg & IDEX_RegWrite;
    assign rsMatch  = IFID_usesRs & (IFID_Rs == IDEX_WriteReg);
    assign rtMatch  = IFID_usesRt & (IFID_Rt == IDEX_WriteReg);
    assign hazard   = exIsLoad & (rsMatch | rtMatch);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: central sequencer for the IF/ID, ID/EX, EX/MEM
// and MEM/WB latches and the PC. Decodes latch enables and bubble inserts from
// load-use hazards, EX-resolved redirects, memory stalls and HALT drain.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall/flush event
// counters; without it stall_cnt and flush_cnt are tied to zero.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned DRAIN_CYCLES = DefaultDrainCycles,
    parameter int unsigned PERF_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_usesRs,
    input  logic                  IFID_usesRt,
    input  logic                  IFID_halt,
    input  logic                  IDEX_MemToReg,
    input  logic                  IDEX_RegWrite,
    input  logic [REG_ADDR_W-1:0] IDEX_WriteReg,
    input  logic                  EX_redirect,
    input  logic                  imem_stall,
    input  logic                  dmem_req,
    input  logic                  dmem_stall,
    input  logic                  dmem_done,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  halted,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic [PERF_W-1:0]     flush_cnt
);

    // Drain counter must hold DRAIN_CYCLES; at least one bit wide.
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES);
    localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);

    ctrlState_e        stateQ, stateD;
    logic [DrainW-1:0] drainCntQ, drainCntD;
    runAction_e        runAction;
    latchCtrl_t        ctrl;
    logic              hazard;
    logic              memHold;

    pipeline_stall_controller_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_usesRs   (IFID_usesRs),
        .IFID_usesRt   (IFID_usesRt),
        .IDEX_MemToReg (IDEX_MemToReg),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_WriteReg (IDEX_WriteReg),
        .hazard        (hazard)
    );

    // A data access is outstanding and the memory cannot accept the pipeline moving.
    assign memHold = dmem_req & dmem_stall;

    // Resolve the single RUN-state action by priority.
    always_comb begin
        runAction = ActNone;
        if (memHold) begin
            runAction = ActMemHold;
        end else if (EX_redirect) begin
            // ID holds a wrong-path instruction, so its hazard or HALT is moot.
            runAction = ActRedirect;
        end else if (imem_stall) begin
            runAction = ActImemStall;
        end else if (hazard) begin
            runAction = ActLoadUse;
        end else if (IFID_halt) begin
            runAction = ActHalt;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StRun;
            drainCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            drainCntQ <= drainCntD;
        end
    end

    // Next-state logic.
    always_comb begin
        stateD    = stateQ;
        drainCntD = drainCntQ;
        unique case (stateQ)
            StRun: begin
                case (runAction)
                    ActMemHold: stateD = StDmemWait;
                    ActHalt: begin
                        stateD    = StDrain;
                        drainCntD = DrainLoad;
                    end
                    default: ;
                endcase
            end
            StDmemWait: begin
                if (dmem_done) begin
                    stateD = StRun;
                end
            end
            StDrain: begin
                // A data stall freezes the drain along with the latches.
                if (!memHold) begin
                    if (drainCntQ <= DrainOne) begin
                        stateD    = StHalted;
                        drainCntD = '0;
                    end else begin
                        drainCntD = drainCntQ - DrainOne;
                    end
                end
            end
            StHalted: ;
            default: stateD = StRun;
        endcase
    end

    // Output decode from state and current inputs; reset forces bubbles everywhere.
    always_comb begin
        ctrl   = CtrlAllEn;
        halted = 1'b0;
        if (rst) begin
            ctrl = CtrlReset;
        end else begin
            unique case (stateQ)
                StRun: begin
                    case (runAction)
                        ActMemHold:   ctrl = CtrlMemHold;
                        ActRedirect:  ctrl = CtrlRedirect;
                        ActImemStall: ctrl = CtrlImemWait;
                        ActLoadUse:   ctrl = CtrlLoadUse;
                        ActHalt:      ctrl = CtrlHaltIss;
                        default:      ctrl = CtrlAllEn;
                    endcase
                end
                StDmemWait: ctrl = dmem_done ? CtrlAllEn : CtrlMemHold;
                StDrain:    ctrl = memHold ? CtrlMemHold : CtrlDrain;
                StHalted: begin
                    ctrl   = CtrlHalted;
                    halted = 1'b1;
                end
                default: ctrl = CtrlReset;
            endcase
        end
    end

    assign pc_en       = ctrl.pcEn;
    assign ifid_en     = ctrl.ifidEn;
    assign idex_en     = ctrl.idexEn;
    assign exmem_en    = ctrl.exmemEn;
    assign memwb_en    = ctrl.memwbEn;
    assign ifid_flush  = ctrl.ifidFlush;
    assign idex_flush  = ctrl.idexFlush;
    assign exmem_flush = ctrl.exmemFlush;
    assign memwb_flush = ctrl.memwbFlush;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stallCntQ;
    logic [PERF_W-1:0] flushCntQ;
    logic              stallEvent;
    logic              flushEvent;

    // Drain-phase PC freezes are not counted as stalls.
    assign stallEvent = ((stateQ == StRun) || (stateQ == StDmemWait)) && !ctrl.pcEn;
    assign flushEvent = (stateQ == StRun) && (runAction == ActRedirect);

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stallEvent && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + PERF_W'(1);
            end
            if (flushEvent && (flushCntQ != '1)) begin
                flushCntQ <= flushCntQ + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios then
// randomized stimulus, all checked against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

    localparam int unsigned RegW        = 3;
    localparam int unsigned DrainCycles = 3;
    localparam int unsigned PerfW       = 4;
    localparam int          PerfMax     = (1 << PerfW) - 1;

    // Expected {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush}.
    localparam logic [8:0] ExpReset    = 9'b00000_1111;
    localparam logic [8:0] ExpAllEn    = 9'b11111_0000;
    localparam logic [8:0] ExpMemHold  = 9'b00001_0001;
    localparam logic [8:0] ExpRedirect = 9'b11111_1100;
    localparam logic [8:0] ExpImem     = 9'b01111_1000;
    localparam logic [8:0] ExpLoadUse  = 9'b00111_0100;
    localparam logic [8:0] ExpHaltIss  = 9'b00111_0000;
    localparam logic [8:0] ExpDrain    = 9'b00111_1000;
    localparam logic [8:0] ExpHalted   = 9'b00000_0000;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [RegW-1:0] IFID_Rs, IFID_Rt, IDEX_WriteReg;
    logic            IFID_usesRs, IFID_usesRt, IFID_halt;
    logic            IDEX_MemToReg, IDEX_RegWrite;
    logic            EX_redirect, imem_stall, dmem_req, dmem_stall, dmem_done;
    logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic            halted;
    logic [PerfW-1:0] stall_cnt, flush_cnt;
    logic [8:0]      dutCtrl;

    int checks = 0;
    int errors = 0;

    // Model state: what the pipeline is doing, in plain terms.
    bit mWaiting, mDraining, mHalted;
    int mDrainLeft, mStalls, mFlushes, mHaltedFor;

    pipeline_stall_controller #(
        .REG_ADDR_W   (RegW),
        .DRAIN_CYCLES (DrainCycles),
        .PERF_W       (PerfW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_usesRs   (IFID_usesRs),
        .IFID_usesRt   (IFID_usesRt),
        .IFID_halt     (IFID_halt),
        .IDEX_MemToReg (IDEX_MemToReg),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_WriteReg (IDEX_WriteReg),
        .EX_redirect   (EX_redirect),
        .imem_stall    (imem_stall),
        .dmem_req      (dmem_req),
        .dmem_stall    (dmem_stall),
        .dmem_done     (dmem_done),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .memwb_flush   (memwb_flush),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    assign dutCtrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic modelReset();
        mWaiting   = 1'b0;
        mDraining  = 1'b0;
        mHalted    = 1'b0;
        mDrainLeft = 0;
        mStalls    = 0;
        mFlushes   = 0;
        mHaltedFor = 0;
    endtask

    task automatic idleInputs();
        IFID_Rs = '0; IFID_Rt = '0; IDEX_WriteReg = '0;
        IFID_usesRs = 1'b0; IFID_usesRt = 1'b0; IFID_halt = 1'b0;
        IDEX_MemToReg = 1'b0; IDEX_RegWrite = 1'b0;
        EX_redirect = 1'b0; imem_stall = 1'b0;
        dmem_req = 1'b0; dmem_stall = 1'b0; dmem_done = 1'b0;
    endtask

    task automatic randInputs();
        IFID_Rs       = RegW'($urandom_range(0, 7));
        IFID_Rt       = RegW'($urandom_range(0, 7));
        IFID_usesRs   = ($urandom_range(0, 1) == 1);
        IFID_usesRt   = ($urandom_range(0, 1) == 1);
        IFID_halt     = ($urandom_range(0, 29) == 0);
        IDEX_MemToReg = ($urandom_range(0, 2) == 0);
        IDEX_RegWrite = ($urandom_range(0, 2) != 0);
        IDEX_WriteReg = ($urandom_range(0, 1) == 1) ? IFID_Rs : RegW'($urandom_range(0, 7));
        EX_redirect   = ($urandom_range(0, 7) == 0);
        imem_stall    = ($urandom_range(0, 5) == 0);
        dmem_req      = ($urandom_range(0, 1) == 1);
        dmem_stall    = ($urandom_range(0, 4) == 0);
        dmem_done     = ($urandom_range(0, 3) == 0);
    endtask

    // Inputs are driven at the falling edge; sample, check, then advance the model.
    task automatic stepCheck(input string tag);
        logic [8:0] expCtrl;
        bit         expHalted, memHold, readsLoad;
        bit         stallInc, flushInc;
        bit         nWaiting, nDraining, nHalted;
        int         nDrainLeft;
        #1;
        if (rst) modelReset();
        memHold   = dmem_req && dmem_stall;
        readsLoad = IDEX_MemToReg && IDEX_RegWrite &&
                    ((IFID_usesRs && (IFID_Rs == IDEX_WriteReg)) ||
                     (IFID_usesRt && (IFID_Rt == IDEX_WriteReg)));
        expHalted  = 1'b0;
        stallInc   = 1'b0;
        flushInc   = 1'b0;
        nWaiting   = mWaiting;
        nDraining  = mDraining;
        nHalted    = mHalted;
        nDrainLeft = mDrainLeft;
        if (rst) begin
            expCtrl = ExpReset;
        end else if (mHalted) begin
            expCtrl   = ExpHalted;
            expHalted = 1'b1;
        end else if (mDraining) begin
            if (memHold) begin
                expCtrl = ExpMemHold;
            end else begin
                expCtrl    = ExpDrain;
                nDrainLeft = mDrainLeft - 1;
                if (nDrainLeft <= 0) begin
                    nDraining = 1'b0;
                    nHalted   = 1'b1;
                end
            end
        end else if (mWaiting) begin
            if (dmem_done) begin
                expCtrl  = ExpAllEn;
                nWaiting = 1'b0;
            end else begin
                expCtrl  = ExpMemHold;
                stallInc = 1'b1;
            end
        end else if (memHold) begin
            expCtrl  = ExpMemHold;
            nWaiting = 1'b1;
            stallInc = 1'b1;
        end else if (EX_redirect) begin
            expCtrl  = ExpRedirect;
            flushInc = 1'b1;
        end else if (imem_stall) begin
            expCtrl  = ExpImem;
            stallInc = 1'b1;
        end else if (readsLoad) begin
            expCtrl  = ExpLoadUse;
            stallInc = 1'b1;
        end else if (IFID_halt) begin
            expCtrl    = ExpHaltIss;
            stallInc   = 1'b1;
            nDraining  = 1'b1;
            nDrainLeft = DrainCycles;
        end else begin
            expCtrl = ExpAllEn;
        end

        checkEq({tag, "/ctrl"}, 32'(dutCtrl), 32'(expCtrl));
        checkEq({tag, "/halted"}, 32'(halted), 32'(expHalted));
        checkEq({tag, "/stall_cnt"}, 32'(stall_cnt),
                PerfOn ? ((mStalls > PerfMax) ? PerfMax : mStalls) : 0);
        checkEq({tag, "/flush_cnt"}, 32'(flush_cnt),
                PerfOn ? ((mFlushes > PerfMax) ? PerfMax : mFlushes) : 0);

        @(posedge clk);
        if (!rst) begin
            mWaiting   = nWaiting;
            mDraining  = nDraining;
            mHalted    = nHalted;
            mDrainLeft = nDrainLeft;
            mStalls    = mStalls + int'(stallInc);
            mFlushes   = mFlushes + int'(flushInc);
            mHaltedFor = mHalted ? mHaltedFor + 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic pulseReset();
        idleInputs();
        rst = 1'b1;
        stepCheck("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        modelReset();
        @(negedge clk);
        stepCheck("por");
        rst = 1'b0;
        stepCheck("idle");

        // lw r1 in EX, add r2,r1,r3 in ID; next cycle EX holds the bubble.
        IDEX_MemToReg = 1'b1; IDEX_RegWrite = 1'b1; IDEX_WriteReg = 3'd1;
        IFID_Rs = 3'd1; IFID_usesRs = 1'b1; IFID_Rt = 3'd3; IFID_usesRt = 1'b1;
        stepCheck("lu_stall");
        IDEX_MemToReg = 1'b0; IDEX_RegWrite = 1'b0;
        stepCheck("lu_resume");
        // Same hazard through Rt only.
        IDEX_MemToReg = 1'b1; IDEX_RegWrite = 1'b1; IDEX_WriteReg = 3'd3;
        stepCheck("lu_rt");

        // Redirect beats load-use and imem stall in the same cycle.
        IDEX_WriteReg = 3'd1; imem_stall = 1'b1; EX_redirect = 1'b1;
        stepCheck("redir_prio");
        idleInputs();

        // Data stall for 4 cycles, completion on the 5th.
        dmem_req = 1'b1; dmem_stall = 1'b1;
        for (int i = 0; i < 4; i++) stepCheck("dmem_hold");
        dmem_stall = 1'b0; dmem_done = 1'b1;
        stepCheck("dmem_done");
        dmem_req = 1'b0; dmem_done = 1'b0;
        // A stray done in RUN changes nothing.
        dmem_done = 1'b1;
        stepCheck("stray_done");
        dmem_done = 1'b0;

        // Reset in the middle of a data wait.
        dmem_req = 1'b1; dmem_stall = 1'b1;
        stepCheck("wait_enter");
        stepCheck("wait_mid");
        pulseReset();
        stepCheck("after_rst");

        // HALT with a 2-cycle data stall during drain.
        IFID_halt = 1'b1;
        stepCheck("halt_issue");
        IFID_halt = 1'b0;
        stepCheck("drain1");
        dmem_req = 1'b1; dmem_stall = 1'b1;
        stepCheck("drain_hold1");
        stepCheck("drain_hold2");
        dmem_req = 1'b0; dmem_stall = 1'b0;
        stepCheck("drain2");
        stepCheck("drain3");
        stepCheck("halted1");
        EX_redirect = 1'b1; imem_stall = 1'b1;
        stepCheck("halted_sticky");
        pulseReset();

        // Counter saturation: 20 fetch stalls, then some redirects.
        imem_stall = 1'b1;
        for (int i = 0; i < 20; i++) stepCheck("sat_stall");
        imem_stall = 1'b0; EX_redirect = 1'b1;
        for (int i = 0; i < 18; i++) stepCheck("sat_flush");
        EX_redirect = 1'b0;
        stepCheck("sat_final");
        pulseReset();

        for (int i = 0; i < 4000; i++) begin
            randInputs();
            rst = (mHaltedFor > 3) || ($urandom_range(0, 199) == 0);
            stepCheck("rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
